multimode_counter: RTL and testbench

Parametrised successor to the single-mode up-counter. Counts through 0..MAX_COUNTER_VALUE, with:
- selectable direction;
- wrap, one-shot and ping-pong modes;
- a clock prescaler;
- a synchronous load;
- a compare-match output.

It sits in the timing/sequencing layer of the design and serves as a generic event or interval counter for the FSMs above it.

---
 rtl/multimode_counter.sv | 115 +++++++++++
 tb/tb_multimode_counter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multimode_counter.sv
// Parametrised up/down event counter with wrap, one-shot and ping-pong modes,
// a clock prescaler, synchronous load and a compare-match output.
module multimode_counter #(
  parameter  int MAX_COUNTER_VALUE = 33,
  parameter  int PRESCALE          = 1,
  localparam int W                 = $clog2(MAX_COUNTER_VALUE + 1),
  localparam int PW                = $clog2(PRESCALE + 1)
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         enable_i,
  input  logic         direction_i,
  input  logic [1:0]   mode_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic [W-1:0] compare_val_i,
  output logic [W-1:0] counter_val_o,
  output logic         dir_o,
  output logic         finished_o,
  output logic         wrap_o,
  output logic         match_o
);

  typedef enum logic [1:0] {
    MODE_WRAP     = 2'b00,
    MODE_ONESHOT  = 2'b01,
    MODE_PINGPONG = 2'b10,
    MODE_RSVD     = 2'b11
  } mode_e;

  localparam logic [W-1:0]  MAX_W   = W'(MAX_COUNTER_VALUE);
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  mode_e         mode;
  logic [W-1:0]  count_q, count_d;
  logic [PW-1:0] prescale_q, prescale_d;
  logic          dir_q, dir_d;
  logic          wrap_q, wrap_d;
  logic          eff_dir;
  logic [W-1:0]  terminal;
  logic          at_terminal;
  logic          tick;
  logic [W-1:0]  load_clamped;
  logic [W-1:0]  step_val;
  logic [W-1:0]  back_val;

  assign mode         = mode_e'(mode_i);
  assign eff_dir      = (mode == MODE_PINGPONG) ? dir_q : direction_i;
  assign terminal     = eff_dir ? '0 : MAX_W;
  assign at_terminal  = (count_q == terminal);
  assign tick         = enable_i && (prescale_q == PS_LAST);
  assign load_clamped = (load_val_i > MAX_W) ? MAX_W : load_val_i;
  // Only evaluated away from the matching bound, so neither can leave [0, MAX].
  assign step_val     = eff_dir ? count_q - W'(1) : count_q + W'(1);
  assign back_val     = eff_dir ? count_q + W'(1) : count_q - W'(1);

  always_comb begin
    count_d    = count_q;
    prescale_d = prescale_q;
    dir_d      = dir_q;
    wrap_d     = 1'b0;
    if (load_i) begin
      count_d    = load_clamped;
      prescale_d = '0;
      dir_d      = direction_i;
    end else if (enable_i) begin
      prescale_d = tick ? '0 : prescale_q + PW'(1);
      if (tick) begin
        case (mode)
          MODE_PINGPONG: begin
            if (at_terminal) begin
              dir_d   = ~dir_q;
              count_d = back_val;
              wrap_d  = 1'b1;
            end else begin
              count_d = step_val;
            end
          end
          MODE_ONESHOT: begin
            if (!at_terminal) count_d = step_val;
          end
          default: begin
            if (at_terminal) begin
              count_d = eff_dir ? MAX_W : '0;
              wrap_d  = 1'b1;
            end else begin
              count_d = step_val;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      count_q    <= '0;
      prescale_q <= '0;
      dir_q      <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      count_q    <= count_d;
      prescale_q <= prescale_d;
      dir_q      <= dir_d;
      wrap_q     <= wrap_d;
    end
  end

  assign counter_val_o = count_q;
  assign dir_o         = eff_dir;
  assign wrap_o        = wrap_q;
  assign finished_o    = (mode == MODE_ONESHOT) && at_terminal;
  assign match_o       = (count_q == compare_val_i);

endmodule

// File: tb/tb_multimode_counter.sv
// Directed bench for multimode_counter: two instances (PRESCALE 1 and 3) share
// stimulus; a reference model fills a scoreboard that is drained after each edge.
module tb_multimode_counter;

  localparam int MAXV = 33;
  localparam int W    = 6;

  logic         clock = 1'b0;
  logic         reset, enable, direction, load;
  logic [1:0]   mode;
  logic [W-1:0] load_val, compare_val;

  logic [W-1:0] cv1, cv3;
  logic         dir1, dir3, fin1, fin3, wrap1, wrap3, match1, match3;

  typedef struct {
    int cnt;
    int wrap;
    int dir;
    int fin;
    int match;
  } exp_t;

  exp_t sb[$];
  int   m_cnt[2], m_dir[2], m_ps[2], m_wrap[2];
  int   ps_lim[2] = '{1, 3};
  int   errors = 0;
  int   checks = 0;
  int   wrap_seen;

  always #5 clock = ~clock;

  multimode_counter #(.MAX_COUNTER_VALUE(MAXV), .PRESCALE(1)) dut (
    .clock_i(clock), .reset_i(reset), .enable_i(enable), .direction_i(direction),
    .mode_i(mode), .load_i(load), .load_val_i(load_val), .compare_val_i(compare_val),
    .counter_val_o(cv1), .dir_o(dir1), .finished_o(fin1), .wrap_o(wrap1), .match_o(match1)
  );

  multimode_counter #(.MAX_COUNTER_VALUE(MAXV), .PRESCALE(3)) dut3 (
    .clock_i(clock), .reset_i(reset), .enable_i(enable), .direction_i(direction),
    .mode_i(mode), .load_i(load), .load_val_i(load_val), .compare_val_i(compare_val),
    .counter_val_o(cv3), .dir_o(dir3), .finished_o(fin3), .wrap_o(wrap3), .match_o(match3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic void model_step(int k);
    int d;
    m_wrap[k] = 0;
    if (reset) begin
      m_cnt[k] = 0; m_ps[k] = 0; m_dir[k] = 0;
    end else if (load) begin
      m_cnt[k] = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
      m_ps[k]  = 0;
      m_dir[k] = int'(direction);
    end else if (enable) begin
      if (m_ps[k] == ps_lim[k] - 1) begin
        m_ps[k] = 0;
        if (mode == 2'b10) begin
          if (m_dir[k] == 0 && m_cnt[k] == MAXV) begin
            m_dir[k] = 1; m_cnt[k] = MAXV - 1; m_wrap[k] = 1;
          end else if (m_dir[k] == 1 && m_cnt[k] == 0) begin
            m_dir[k] = 0; m_cnt[k] = 1; m_wrap[k] = 1;
          end else begin
            m_cnt[k] = m_cnt[k] + ((m_dir[k] == 1) ? -1 : 1);
          end
        end else begin
          d = int'(direction);
          if (m_cnt[k] == ((d == 1) ? 0 : MAXV)) begin
            if (mode != 2'b01) begin
              m_cnt[k] = (d == 1) ? MAXV : 0; m_wrap[k] = 1;
            end
          end else begin
            m_cnt[k] = m_cnt[k] + ((d == 1) ? -1 : 1);
          end
        end
      end else begin
        m_ps[k]++;
      end
    end
  endfunction

  function automatic exp_t model_out(int k);
    exp_t e;
    e.cnt   = m_cnt[k];
    e.wrap  = m_wrap[k];
    e.dir   = (mode == 2'b10) ? m_dir[k] : int'(direction);
    e.fin   = (mode == 2'b01 && m_cnt[k] == ((direction == 1'b1) ? 0 : MAXV)) ? 1 : 0;
    e.match = (m_cnt[k] == int'(compare_val)) ? 1 : 0;
    return e;
  endfunction

  task automatic checkOutput();
    exp_t e1, e3;
    e1 = sb.pop_front();
    e3 = sb.pop_front();
    check("p1.cnt",   cv1,    e1.cnt);
    check("p1.wrap",  wrap1,  e1.wrap);
    check("p1.dir",   dir1,   e1.dir);
    check("p1.fin",   fin1,   e1.fin);
    check("p1.match", match1, e1.match);
    check("p3.cnt",   cv3,    e3.cnt);
    check("p3.wrap",  wrap3,  e3.wrap);
    check("p3.dir",   dir3,   e3.dir);
    check("p3.fin",   fin3,   e3.fin);
    check("p3.match", match3, e3.match);
  endtask

  task automatic applyStimulus(input int n);
    repeat (n) begin
      model_step(0);
      model_step(1);
      sb.push_back(model_out(0));
      sb.push_back(model_out(1));
      @(posedge clock);
      #1;
      checkOutput();
      if (wrap1 === 1'b1) wrap_seen++;
    end
  endtask

  initial begin
    reset = 1; enable = 0; direction = 0; load = 0;
    mode = 2'b00; load_val = '0; compare_val = 6'd7;
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_dir[k] = 0; m_ps[k] = 0; m_wrap[k] = 0;
    end
    #2;

    // Reset, then five enabled cycles.
    applyStimulus(2);
    check("rst.cnt", cv1, 0);
    check("rst.wrap", wrap1, 0);
    check("rst.fin", fin1, 0);
    reset = 0; enable = 1;
    applyStimulus(5);
    check("en5.cnt", cv1, 5);
    check("en5.p3cnt", cv3, 1);

    // Wrap up from 0.
    load = 1; load_val = 0;
    applyStimulus(1);
    load = 0;
    applyStimulus(33);
    check("wrapup.at33", cv1, 33);
    check("wrapup.nowrap", wrap1, 0);
    applyStimulus(1);
    check("wrapup.cnt0", cv1, 0);
    check("wrapup.pulse", wrap1, 1);
    applyStimulus(1);
    check("wrapup.cnt1", cv1, 1);
    check("wrapup.pulseend", wrap1, 0);

    // Wrap down from 0.
    direction = 1; load = 1; load_val = 0;
    applyStimulus(1);
    load = 0;
    applyStimulus(1);
    check("wrapdn.cnt", cv1, 33);
    check("wrapdn.pulse", wrap1, 1);

    // One-shot up.
    direction = 0; mode = 2'b01; load = 1; load_val = 0;
    applyStimulus(1);
    load = 0; wrap_seen = 0;
    applyStimulus(33);
    check("os.at33", cv1, 33);
    applyStimulus(7);
    check("os.hold", cv1, 33);
    check("os.fin", fin1, 1);
    check("os.nowrap", wrap_seen, 0);
    load = 1; load_val = 10;
    applyStimulus(1);
    load = 0;
    check("os.load", cv1, 10);
    check("os.finclr", fin1, 0);

    // Ping-pong around the top bound, then down to the bottom bound.
    mode = 2'b10; load = 1; load_val = 31;
    applyStimulus(1);
    load = 0;
    check("pp.load", cv1, 31);
    applyStimulus(1);
    check("pp.32", cv1, 32);
    applyStimulus(1);
    check("pp.33", cv1, 33);
    check("pp.33wrap", wrap1, 0);
    applyStimulus(1);
    check("pp.bounce", cv1, 32);
    check("pp.bwrap", wrap1, 1);
    check("pp.bdir", dir1, 1);
    applyStimulus(1);
    check("pp.31", cv1, 31);
    check("pp.31wrap", wrap1, 0);
    applyStimulus(31);
    check("pp.bottom", cv1, 0);
    check("pp.botwrap", wrap1, 0);
    applyStimulus(1);
    check("pp.up1", cv1, 1);
    check("pp.up1wrap", wrap1, 1);
    check("pp.up1dir", dir1, 0);

    // Prescaler and enable gaps on the PRESCALE=3 instance.
    mode = 2'b00; enable = 0; load = 1; load_val = 0;
    applyStimulus(1);
    load = 0; enable = 1;
    applyStimulus(9);
    check("ps.9", cv3, 3);
    enable = 0;
    applyStimulus(2);
    check("ps.hold", cv3, 3);
    enable = 1;
    applyStimulus(3);
    check("ps.resume", cv3, 4);
    enable = 0; load = 1; load_val = 6'd50;
    applyStimulus(1);
    load = 0;
    check("ps.clamp3", cv3, 33);
    check("ps.clamp1", cv1, 33);

    // Compare match, load-vs-tick and reset-vs-load priority.
    load = 1; load_val = 0;
    applyStimulus(1);
    load = 0; enable = 1;
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1);
      check("match.cnt", cv1, i);
      check("match.lvl", match1, (i == 7) ? 1 : 0);
    end
    load = 1; load_val = 20;
    applyStimulus(1);
    check("prio.load", cv1, 20);
    check("prio.nowrap", wrap1, 0);
    reset = 1; mode = 2'b01; direction = 1;
    applyStimulus(1);
    check("prio.rst", cv1, 0);
    check("prio.rstfin", fin1, 1);
    reset = 0; load = 0; enable = 0;
    applyStimulus(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
